// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU (alu_seq) and its popcount helper.
package alu_seq_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [3:0] {
        OP_LOAD    = 4'd0,
        OP_STORE   = 4'd1,
        OP_XOR     = 4'd2,
        OP_COUNT1S = 4'd3,
        OP_ADD     = 4'd4,
        OP_MOV1    = 4'd5,
        OP_MOV2    = 4'd6,
        OP_CLRC    = 4'd7,
        OP_JLT     = 4'd8,
        OP_JLE     = 4'd9,
        OP_JGE     = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // COUNT1s is the only opcode that takes more than one cycle.
    function automatic logic is_iterative(input alu_op_t op);
        return (op == OP_COUNT1S);
    endfunction

endpackage

// File: rtl/alu_popcnt.sv
// Iterative popcount: consumes CNT_STEP bits per cycle, W/CNT_STEP cycles after i_start.
// o_last/o_sum are combinational so the caller can register the final sum on the last step.
module alu_popcnt #(
    parameter int W        = 8,
    parameter int CNT_STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_data,
    output logic         o_last,
    output logic [W-1:0] o_sum
);

    localparam int STEPS = W / CNT_STEP;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((W % CNT_STEP) != 0) begin : g_bad_step
        $error("alu_popcnt: CNT_STEP (%0d) must divide W (%0d)", CNT_STEP, W);
    end

    logic          r_busy;
    logic [W-1:0]  r_data;
    logic [W-1:0]  r_count;
    logic [SW-1:0] r_step;
    logic [W-1:0]  w_chunk;

    // Ones in the low CNT_STEP bits of the working shift register.
    always_comb begin
        w_chunk = '0;
        for (int i = 0; i < CNT_STEP; i++) begin
            w_chunk = w_chunk + W'(r_data[i]);
        end
    end

    assign o_sum  = r_count + w_chunk;
    assign o_last = r_busy && (r_step == SW'(STEPS - 1));

    // Shift-and-add iteration; a reset discards any count in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
            r_step  <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_data  <= i_data;
            r_count <= '0;
            r_step  <= '0;
        end else if (r_busy) begin
            r_data  <= r_data >> CNT_STEP;
            r_count <= o_sum;
            r_step  <= r_step + SW'(1);
            if (o_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready command and result handshakes, sticky carry and iterative COUNT1s.
// Optional macro ALU_FLAGS_EN adds registered zero/parity flag outputs.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int CNT_STEP = 1,
    parameter int CMD_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] alu_cmd,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     rslt,
    output logic [W-1:0]     store,
    output logic             je,
    output logic             sc_o
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             pari
`endif
);

    if (CMD_W < 4) begin : g_bad_cmd_w
        $error("alu_seq: CMD_W (%0d) must be at least 4", CMD_W);
    end

    alu_state_t r_state, w_state_nxt;
    logic [W-1:0] r_rslt, r_store, w_rslt_nxt, w_store_nxt;
    logic         r_je, r_carry, w_je_nxt, w_carry_nxt;

    logic         w_in_ready, w_accept, w_start, w_hi_zero;
    alu_op_t      w_op;
    logic [W:0]   w_add;
    logic [W-1:0] w_op_rslt, w_op_store;
    logic         w_op_je, w_op_carry;
    logic         w_pc_last;
    logic [W-1:0] w_pc_sum;

    // Opcode bits above the defined range make the command a reserved no-op.
    if (CMD_W > 4) begin : g_cmd_hi
        assign w_hi_zero = ~|alu_cmd[CMD_W-1:4];
    end else begin : g_cmd_exact
        assign w_hi_zero = 1'b1;
    end

    assign w_op       = alu_op_t'(alu_cmd[3:0]);
    assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_start    = w_accept && w_hi_zero && is_iterative(w_op);
    assign w_add      = {1'b0, in_a} + {1'b0, acc} + (W+1)'(r_carry);

    // Single-cycle opcode results, evaluated on the live operands at the accept edge.
    always_comb begin
        w_op_rslt  = '0;
        w_op_store = '0;
        w_op_je    = 1'b0;
        w_op_carry = r_carry;
        if (w_hi_zero) begin
            case (w_op)
                OP_LOAD:    w_op_rslt = acc;
                OP_STORE: begin
                    w_op_rslt  = acc;
                    w_op_store = in_a;
                end
                OP_XOR:     w_op_rslt = in_a ^ acc;
                OP_COUNT1S: w_op_rslt = '0;
                OP_ADD:     {w_op_carry, w_op_rslt} = w_add;
                OP_MOV1:    w_op_rslt = in_a;
                OP_MOV2:    w_op_rslt = acc;
                OP_CLRC:    w_op_carry = 1'b0;
                OP_JLT:     w_op_je = (in_a < in_b);
                OP_JLE:     w_op_je = (in_a <= in_b);
                OP_JGE:     w_op_je = (in_a >= in_b);
                default:    w_op_rslt = '0;
            endcase
        end else begin
            w_op_rslt = '0;
        end
    end

    alu_popcnt #(
        .W        (W),
        .CNT_STEP (CNT_STEP)
    ) u_popcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_data  (in_a),
        .o_last  (w_pc_last),
        .o_sum   (w_pc_sum)
    );

    // Control sequencing; outputs hold their values unless a new result lands.
    always_comb begin
        w_state_nxt = r_state;
        w_rslt_nxt  = r_rslt;
        w_store_nxt = r_store;
        w_je_nxt    = r_je;
        w_carry_nxt = r_carry;
        if (w_accept) begin
            w_carry_nxt = w_op_carry;
            if (w_start) begin
                w_state_nxt = BUSY;
            end else begin
                w_state_nxt = DONE;
                w_rslt_nxt  = w_op_rslt;
                w_store_nxt = w_op_store;
                w_je_nxt    = w_op_je;
            end
        end else if ((r_state == BUSY) && w_pc_last) begin
            w_state_nxt = DONE;
            w_rslt_nxt  = w_pc_sum;
            w_store_nxt = '0;
            w_je_nxt    = 1'b0;
        end else if ((r_state == DONE) && out_ready) begin
            w_state_nxt = IDLE;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rslt  <= '0;
            r_store <= '0;
            r_je    <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rslt  <= w_rslt_nxt;
            r_store <= w_store_nxt;
            r_je    <= w_je_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == DONE);
    assign rslt      = r_rslt;
    assign store     = r_store;
    assign je        = r_je;
    assign sc_o      = r_carry;

`ifdef ALU_FLAGS_EN
    logic r_zero, r_pari, w_rslt_ld;

    function automatic logic f_parity(input logic [W-1:0] v);
        return ^v;
    endfunction

    assign w_rslt_ld = (w_accept && !w_start) || ((r_state == BUSY) && w_pc_last);

    // Flags are captured together with the result they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_pari <= 1'b0;
        end else if (w_rslt_ld) begin
            r_zero <= (w_rslt_nxt == '0);
            r_pari <= f_parity(w_rslt_nxt);
        end
    end

    assign zero = r_zero;
    assign pari = r_pari;
`endif

endmodule
